// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
// mult/multu/div/divu run for a fixed number of busy cycles. mthi/mtlo write
// HI or LO at the next edge. mfhi/mflo read them combinationally.
// Optional feature macro: E_MDU_MADD_EN adds madd/maddu (accumulate into HI/LO).
// When it is undefined, MDUOp 9/10 behave like "none".
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic        pending,
    output logic [31:0] result,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef E_MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_mult_op;
    logic               is_div_op;

    logic signed [63:0] mul_s;
    logic [63:0]        mul_u;
    logic               div_zero;
    logic [31:0]        a_mag, b_mag, b_safe_s, b_safe_u;
    logic [31:0]        q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Decode which incoming ops start a multi-cycle run
    always_comb begin
        is_mult_op = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef E_MDU_MADD_EN
        is_mult_op = is_mult_op || (MDUOp == OP_MADD) || (MDUOp == OP_MADDU);
`endif
        is_div_op  = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    end

    // Arithmetic on the latched operands; only consumed on the final RUN cycle
    always_comb begin
        mul_s    = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        mul_u    = {32'd0, a_q} * {32'd0, b_q};
        div_zero = (b_q == 32'd0);
        // Sign-magnitude division gives truncation toward zero; the magnitude
        // of 0x80000000 is representable as an unsigned 32-bit value.
        a_mag    = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;
        b_safe_s = div_zero ? 32'd1 : b_mag;
        b_safe_u = div_zero ? 32'd1 : b_q;
        q_mag    = a_mag / b_safe_s;
        r_mag    = a_mag % b_safe_s;
        q_s      = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s      = a_q[31] ? (~r_mag + 32'd1) : r_mag;
        q_u      = a_q / b_safe_u;
        r_u      = a_q % b_safe_u;
    end

    // Next-state logic: accept ops in IDLE, count down in RUN, commit HI/LO on the last cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult_op) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = MDUOp;
                        cnt_d   = CNT_W'(MULT_CYCLES);
                        state_d = ST_RUN;
                    end else if (is_div_op) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = MDUOp;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        state_d = ST_RUN;
                    end else if (MDUOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDUOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    op_d    = OP_NONE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = mul_s;
                        OP_MULTU: {hi_d, lo_d} = mul_u;
                        OP_DIV: begin
                            if (!div_zero) begin
                                hi_d = r_s;
                                lo_d = q_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                hi_d = r_u;
                                lo_d = q_u;
                            end
                        end
`ifdef E_MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + mul_s;
                        OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + mul_u;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any run in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Status and read-back outputs
    always_comb begin
        busy    = (state_q == ST_RUN);
        pending = (start && (is_mult_op || is_div_op)) || busy;
        hi_out  = hi_q;
        lo_out  = lo_q;
        case (MDUOp)
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu with default cycle counts.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_e_mdu;

    logic        clk;
    logic        reset_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic        pending;
    logic [31:0] result;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_tests;
    int n_fail;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .MDUOp   (MDUOp),
        .start   (start),
        .busy    (busy),
        .pending (pending),
        .result  (result),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op for one cycle, then count busy cycles (bounded) until idle
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles);
        @(negedge clk);
        MDUOp = op; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; MDUOp = 4'd7; A = '0; B = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (pending !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pending got %b exp 0", pending); end
        n_tests++; if (hi_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hi got %h exp 0", hi_out); end
        n_tests++; if (lo_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_lo got %h exp 0", lo_out); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result got %h exp 0", result); end
        reset_n = 1'b1; MDUOp = 4'd0;
    endtask

    task automatic test_pending();
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd1; #1;
        n_tests++; if (pending !== 1'b1) begin n_fail++; $display("[TB] FAIL pending_mult got %b exp 1", pending); end
        MDUOp = 4'd4; #1;
        n_tests++; if (pending !== 1'b1) begin n_fail++; $display("[TB] FAIL pending_divu got %b exp 1", pending); end
        MDUOp = 4'd5; #1;
        n_tests++; if (pending !== 1'b0) begin n_fail++; $display("[TB] FAIL pending_mthi got %b exp 0", pending); end
        start = 1'b0; MDUOp = 4'd1; #1;
        n_tests++; if (pending !== 1'b0) begin n_fail++; $display("[TB] FAIL pending_nostart got %b exp 0", pending); end
        MDUOp = 4'd0;
    endtask

    task automatic test_mult();
        int bc;
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, bc);
        n_tests++; if (bc != 5) begin n_fail++; $display("[TB] FAIL mult_busy got %0d exp 5", bc); end
        n_tests++; if (hi_out !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL mult_hi got %h exp ffffffff", hi_out); end
        n_tests++; if (lo_out !== 32'hFFFFFFFA) begin n_fail++; $display("[TB] FAIL mult_lo got %h exp fffffffa", lo_out); end
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, bc);
        n_tests++; if (bc != 5) begin n_fail++; $display("[TB] FAIL multu_busy got %0d exp 5", bc); end
        n_tests++; if (hi_out !== 32'h2) begin n_fail++; $display("[TB] FAIL multu_hi got %h exp 2", hi_out); end
        n_tests++; if (lo_out !== 32'hFFFFFFFA) begin n_fail++; $display("[TB] FAIL multu_lo got %h exp fffffffa", lo_out); end
    endtask

    task automatic test_div();
        int bc;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, bc);
        n_tests++; if (bc != 10) begin n_fail++; $display("[TB] FAIL div_busy got %0d exp 10", bc); end
        n_tests++; if (lo_out !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL div_lo got %h exp fffffffd", lo_out); end
        n_tests++; if (hi_out !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL div_hi got %h exp ffffffff", hi_out); end
        run_op(4'd4, 32'd1234, 32'd0, bc);
        n_tests++; if (bc != 10) begin n_fail++; $display("[TB] FAIL divz_busy got %0d exp 10", bc); end
        n_tests++; if (lo_out !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL divz_lo got %h exp fffffffd", lo_out); end
        n_tests++; if (hi_out !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL divz_hi got %h exp ffffffff", hi_out); end
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, bc);
        n_tests++; if (lo_out !== 32'h80000000) begin n_fail++; $display("[TB] FAIL divmin_lo got %h exp 80000000", lo_out); end
        n_tests++; if (hi_out !== 32'h0) begin n_fail++; $display("[TB] FAIL divmin_hi got %h exp 0", hi_out); end
        run_op(4'd3, 32'd7, 32'hFFFFFFFE, bc);
        n_tests++; if (lo_out !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL divneg_lo got %h exp fffffffd", lo_out); end
        n_tests++; if (hi_out !== 32'h1) begin n_fail++; $display("[TB] FAIL divneg_hi got %h exp 1", hi_out); end
        run_op(4'd4, 32'hFFFFFFF9, 32'd2, bc);
        n_tests++; if (lo_out !== 32'h7FFFFFFC) begin n_fail++; $display("[TB] FAIL divu_lo got %h exp 7ffffffc", lo_out); end
        n_tests++; if (hi_out !== 32'h1) begin n_fail++; $display("[TB] FAIL divu_hi got %h exp 1", hi_out); end
    endtask

    task automatic test_move();
        int bc;
        run_op(4'd5, 32'h12345678, 32'd0, bc);
        n_tests++; if (bc != 0) begin n_fail++; $display("[TB] FAIL mthi_busy got %0d exp 0", bc); end
        MDUOp = 4'd7; #1;
        n_tests++; if (result !== 32'h12345678) begin n_fail++; $display("[TB] FAIL mfhi_result got %h exp 12345678", result); end
        MDUOp = 4'd8; #1;
        n_tests++; if (result !== 32'h7FFFFFFC) begin n_fail++; $display("[TB] FAIL mflo_result got %h exp 7ffffffc", result); end
        run_op(4'd6, 32'hCAFEBABE, 32'd0, bc);
        MDUOp = 4'd8; #1;
        n_tests++; if (result !== 32'hCAFEBABE) begin n_fail++; $display("[TB] FAIL mtlo_result got %h exp cafebabe", result); end
        MDUOp = 4'd0; #1;
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("[TB] FAIL none_result got %h exp 0", result); end
    endtask

    task automatic test_back_to_back();
        int bc;
        bc = 0;
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(negedge clk);
        if (busy === 1'b1) bc++;
        MDUOp = 4'd3; A = 32'd100; B = 32'd7; #1;
        n_tests++; if (pending !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_pending got %b exp 1", pending); end
        MDUOp = 4'd7; #1;
        n_tests++; if (result !== 32'h12345678) begin n_fail++; $display("[TB] FAIL busy_mfhi_old got %h exp 12345678", result); end
        @(negedge clk);
        if (busy === 1'b1) bc++;
        MDUOp = 4'd5; A = 32'hDEADBEEF;
        @(negedge clk);
        if (busy === 1'b1) bc++;
        start = 1'b0; MDUOp = 4'd0;
        @(negedge clk);
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        n_tests++; if (bc != 5) begin n_fail++; $display("[TB] FAIL ignore_busy got %0d exp 5", bc); end
        n_tests++; if (hi_out !== 32'h0) begin n_fail++; $display("[TB] FAIL ignore_hi got %h exp 0", hi_out); end
        n_tests++; if (lo_out !== 32'h1) begin n_fail++; $display("[TB] FAIL ignore_lo got %h exp 1", lo_out); end
    endtask

    task automatic test_reset_abort();
        int bc;
        run_op(4'd5, 32'h00000055, 32'd0, bc);
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd1; A = 32'd2; B = 32'd3;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_started got %b exp 1", busy); end
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy got %b exp 0", busy); end
        n_tests++; if (hi_out !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_hi got %h exp 0", hi_out); end
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        n_tests++; if (lo_out !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_lo_later got %h exp 0", lo_out); end
        n_tests++; if (hi_out !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_hi_later got %h exp 0", hi_out); end
    endtask

    task automatic test_madd();
        int bc;
        run_op(4'd5, 32'h0, 32'd0, bc);
        run_op(4'd6, 32'hFFFFFFFF, 32'd0, bc);
`ifdef E_MDU_MADD_EN
        run_op(4'd10, 32'd1, 32'd1, bc);
        n_tests++; if (bc != 5) begin n_fail++; $display("[TB] FAIL maddu_busy got %0d exp 5", bc); end
        n_tests++; if (hi_out !== 32'h1) begin n_fail++; $display("[TB] FAIL maddu_hi got %h exp 1", hi_out); end
        n_tests++; if (lo_out !== 32'h0) begin n_fail++; $display("[TB] FAIL maddu_lo got %h exp 0", lo_out); end
        run_op(4'd9, 32'hFFFFFFFF, 32'd1, bc);
        n_tests++; if (hi_out !== 32'h0) begin n_fail++; $display("[TB] FAIL madd_hi got %h exp 0", hi_out); end
        n_tests++; if (lo_out !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL madd_lo got %h exp ffffffff", lo_out); end
`else
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd9; A = 32'd1; B = 32'd1; #1;
        n_tests++; if (pending !== 1'b0) begin n_fail++; $display("[TB] FAIL madd_off_pending got %b exp 0", pending); end
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL madd_off_busy got %b exp 0", busy); end
        repeat (6) @(negedge clk);
        n_tests++; if (hi_out !== 32'h0) begin n_fail++; $display("[TB] FAIL madd_off_hi got %h exp 0", hi_out); end
        n_tests++; if (lo_out !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL madd_off_lo got %h exp ffffffff", lo_out); end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_pending();
        test_mult();
        test_div();
        test_move();
        test_back_to_back();
        test_reset_abort();
        test_madd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
